pic_ctl: RTL
============

# pic_ctl

Eight-input programmable interrupt controller, 8259-style. It sits between the peripheral interrupt sources (PIT tick, keyboard, SD, spares) and the CPU's `intr`/`intr_latch` toggle handshake, and is programmed through the I/O port bus at 0x20/0x21. It latches request edges, applies the mask, resolves fixed priority with nesting, and presents one vector at a time. It also tracks in-service levels until EOI.

## Interface
- `VECT_RESET`, default 8'h08: vector base after reset; bits [2:0] ignored.
- `clock`  in  1: CPU host clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `irq_in`  in  8: request lines, rising-edge triggered, synchronous to `clock`; bit 0 = IRQ0.
- `port_clk`  in  1: one-cycle I/O strobe.
- `port`  in  16: I/O address.
- `port_o`  in  8: write data from the CPU.
- `port_w`  in  1: 1 = write, 0 = read.
- `port_i`  out  8: read data to the CPU.
- `intr`  out  1: request toggle; a request is outstanding while `intr != intr_latch`.
- `irq`  out  8: vector number, valid whenever a request is outstanding.
- `intr_latch`  in  1: CPU acknowledge toggle; the CPU copies `intr` here on accept.

## Operation
- Registers: IRR[7:0] (requests), IMR[7:0] (mask), ISR[7:0] (in-service), base[7:3], rsel (OCW3 read select), init (ICW2 expected), and `irq_prev` for edge detection.
- Edge detection:
  - Any line with `irq_in & ~irq_prev` sets its IRR bit, including masked lines.
  - A set and a clear of the same IRR bit in one cycle: set wins.
- FSM IDLE: winner n = lowest-numbered bit of IRR & ~IMR whose priority is strictly higher than the lowest-numbered ISR bit (or ISR == 0).
  - If a winner exists: `irq <= {base, n}`, IRR[n] cleared, ISR[n] set, `intr <= ~intr_latch`, go to WAIT.
- FSM WAIT: stay until `intr_latch == intr`, then return to IDLE. No new request is raised while in WAIT.
- Port writes (`port_clk & port_w`):
  - 0x20, bit4 = 1 (ICW1): init = 1, ISR = 0, IRR = 0, rsel = IRR.
  - 0x20, bits[4:3] = 00, bit5 = 1 (OCW2 EOI):
    - bit6 = 0: non-specific, clears the lowest-numbered set ISR bit.
    - bit6 = 1: specific, clears ISR[port_o[2:0]].
    - EOI with ISR == 0 is a no-op.
  - 0x20, bits[4:3] = 01 (OCW3): if bit1 = 1, rsel = bit0 (0 = IRR, 1 = ISR).
  - 0x21: if init = 1, base = port_o[7:3] and init = 0; otherwise IMR = port_o.
- Port reads (`port_clk & ~port_w`):
  - 0x20: `port_i` = IRR or ISR, per rsel.
  - 0x21: `port_i` = IMR.
  - Any other address: `port_i` unchanged.

## Timing
- Reset values:
  - `intr <= intr_latch`, so no spurious request.
  - `irq` = 0, `port_i` = 0.
  - IRR = ISR = IMR = 0, base = `VECT_RESET[7:3]`, rsel = IRR, init = 0, FSM = IDLE.
  - `irq_prev <= irq_in`, so lines already high are not taken as edges.
- Latency:
  - Edge sampled at clock t sets IRR at t.
  - `intr`/`irq` update at t+1 if the FSM is IDLE and the line is unmasked.
- Port register effects are visible to the resolver on the next cycle. An IMR write and an edge in the same cycle both take effect.
- An EOI written while in WAIT affects only the next resolution.
- Reset asserted in WAIT: abandons the request, FSM = IDLE, `intr <= intr_latch`.

## Configuration
- `PIC_AEOI_EN`
  - Defined: automatic EOI. ISR is never set on raise, so nesting is disabled and every unmasked request is served in priority order as soon as the FSM is IDLE. OCW2 EOI writes are accepted and have no effect.
  - Undefined: normal EOI as described in Operation.

## Structure
- Package `pic_pkg`:
  - Port addresses PIC_CMD = 16'h20, PIC_DATA = 16'h21.
  - ICW1/OCW2/OCW3 bit positions.
  - State enum {PIC_IDLE, PIC_WAIT}.
  - Function `prio_lowest(logic [7:0]) -> {valid, idx[2:0]}`.
- Sub-module `pic_prio`: combinational resolver taking IRR, IMR and ISR, producing valid and n. The top holds the registers, FSM and port decode.

## Test plan
1. Reset with `intr_latch` = 1 → `intr` = 1, `irq` = 0; read 0x21 → 0x00.
2. Edge on IRQ0:
   - `intr` toggles 1 clock after the IRR set, `irq` = 0x08.
   - Ack, then a second IRQ0 edge gives no request until 0x20 ← 0x20 (EOI); next request follows 1 clock after EOI.
3. Simultaneous edges IRQ1 and IRQ3 → `irq` = 0x09; after ack + EOI → 0x0B.
4. Masking:
   - 0x21 ← 0x02, IRQ1 edge → no toggle.
   - 0x20 ← 0x0A, read 0x20 → 0x02.
   - 0x21 ← 0x00 → request with `irq` = 0x09.
5. 0x20 ← 0x11, 0x21 ← 0x70, then IRQ0 edge → `irq` = 0x70, IMR unchanged.
6. Nesting:
   - IRQ3 in service, IRQ0 edge → `irq` = 0x08 before IRQ3's EOI.
   - 0x20 ← 0x63 clears ISR[3] only; read ISR (0x0B) → 0x01.
   - With `PIC_AEOI_EN` defined, ISR reads 0x00.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: shared constants, FSM states and priority helper for the pic_ctl interrupt controller
package pic_pkg;
  localparam logic [15:0] PIC_CMD  = 16'h0020;
  localparam logic [15:0] PIC_DATA = 16'h0021;
  localparam int ICW1_BIT     = 4;
  localparam int OCW_SEL_BIT  = 3;
  localparam int OCW2_EOI_BIT = 5;
  localparam int OCW2_SL_BIT  = 6;
  localparam int OCW3_RR_BIT  = 1;
  localparam int OCW3_RIS_BIT = 0;
  typedef enum logic {PIC_IDLE, PIC_WAIT} pic_state_e;
  // returns {valid, index of lowest set bit}; lowest index is highest priority
  function automatic logic [3:0] prio_lowest(input logic [7:0] v);
    prio_lowest = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) prio_lowest = {1'b1, 3'(i)};
  endfunction
endpackage

// File: rtl/pic_prio.sv
// pic_prio: combinational fixed-priority resolver with in-service nesting
module pic_prio
  import pic_pkg::*;
(
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  output logic       valid,
  output logic [2:0] n
);
  logic [3:0] req_w;
  logic [3:0] isr_w;
  // pick the best unmasked request and admit it only if it outranks everything in service
  always_comb begin
    req_w = prio_lowest(irr & ~imr);
    isr_w = prio_lowest(isr);
    n     = req_w[2:0];
    valid = req_w[3] && (!isr_w[3] || (req_w[2:0] < isr_w[2:0]));
  end
endmodule

// File: rtl/pic_ctl.sv
// pic_ctl: 8259-style interrupt controller with port decode, edge capture and toggle handshake; PIC_AEOI_EN selects automatic EOI
module pic_ctl
  import pic_pkg::*;
#(
  parameter logic [7:0] VECT_RESET = 8'h08
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq_in,
  input  logic        port_clk,
  input  logic [15:0] port,
  input  logic [7:0]  port_o,
  input  logic        port_w,
  output logic [7:0]  port_i,
  output logic        intr,
  output logic [7:0]  irq,
  input  logic        intr_latch
);
  logic [7:0] irr_q, irr_d, imr_q, imr_d, isr_q, isr_d;
  logic [7:0] irq_q, irq_d, port_i_q, port_i_d, irq_prev_q;
  logic [4:0] base_q, base_d;
  logic       rsel_q, rsel_d, init_q, init_d, intr_q, intr_d;
  pic_state_e state_q, state_d;
  logic       win_v;
  logic [2:0] win_n;
  logic       wr_cmd, wr_data, rd_cmd, rd_data, icw1, ocw3, eoi, raise;
  logic [7:0] edge_v, raise_m, eoi_m;

  pic_prio u_prio (
    .irr   (irr_q),
    .imr   (imr_q),
    .isr   (isr_q),
    .valid (win_v),
    .n     (win_n)
  );

  // port decode, edge capture and next-state for every register
  always_comb begin
    wr_cmd   = port_clk && port_w && (port == PIC_CMD);
    wr_data  = port_clk && port_w && (port == PIC_DATA);
    rd_cmd   = port_clk && !port_w && (port == PIC_CMD);
    rd_data  = port_clk && !port_w && (port == PIC_DATA);
    icw1     = wr_cmd && port_o[ICW1_BIT];
    ocw3     = wr_cmd && !port_o[ICW1_BIT] && port_o[OCW_SEL_BIT];
    eoi      = wr_cmd && !port_o[ICW1_BIT] && !port_o[OCW_SEL_BIT] && port_o[OCW2_EOI_BIT];
    edge_v   = irq_in & ~irq_prev_q;
    raise    = (state_q == PIC_IDLE) && win_v;
    raise_m  = raise ? (8'd1 << win_n) : 8'd0;
    eoi_m    = !eoi ? 8'd0 : port_o[OCW2_SL_BIT] ? (8'd1 << port_o[2:0]) : (isr_q & (~isr_q + 8'd1));
    irr_d    = (icw1 ? 8'd0 : (irr_q & ~raise_m)) | edge_v;
`ifdef PIC_AEOI_EN
    isr_d    = icw1 ? 8'd0 : isr_q;
`else
    isr_d    = icw1 ? 8'd0 : ((isr_q & ~eoi_m) | raise_m);
`endif
    imr_d    = (wr_data && !init_q) ? port_o : imr_q;
    base_d   = (wr_data && init_q) ? port_o[7:3] : base_q;
    init_d   = icw1 ? 1'b1 : wr_data ? 1'b0 : init_q;
    rsel_d   = icw1 ? 1'b0 : (ocw3 && port_o[OCW3_RR_BIT]) ? port_o[OCW3_RIS_BIT] : rsel_q;
    port_i_d = rd_cmd ? (rsel_q ? isr_q : irr_q) : rd_data ? imr_q : port_i_q;
    state_d  = (state_q == PIC_IDLE) ? (raise ? PIC_WAIT : PIC_IDLE)
                                     : ((intr_latch == intr_q) ? PIC_IDLE : PIC_WAIT);
    intr_d   = raise ? ~intr_latch : intr_q;
    irq_d    = raise ? {base_q, win_n} : irq_q;
  end

  // register file and FSM; reset aligns intr and edge history with the live inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      irr_q      <= 8'd0;
      imr_q      <= 8'd0;
      isr_q      <= 8'd0;
      irq_q      <= 8'd0;
      port_i_q   <= 8'd0;
      irq_prev_q <= irq_in;
      base_q     <= VECT_RESET[7:3];
      rsel_q     <= 1'b0;
      init_q     <= 1'b0;
      intr_q     <= intr_latch;
      state_q    <= PIC_IDLE;
    end else begin
      irr_q      <= irr_d;
      imr_q      <= imr_d;
      isr_q      <= isr_d;
      irq_q      <= irq_d;
      port_i_q   <= port_i_d;
      irq_prev_q <= irq_in;
      base_q     <= base_d;
      rsel_q     <= rsel_d;
      init_q     <= init_d;
      intr_q     <= intr_d;
      state_q    <= state_d;
    end
  end

  assign port_i = port_i_q;
  assign intr   = intr_q;
  assign irq    = irq_q;
endmodule
